// File: rtl/ripple_cap_pkg.sv
// rtl/ripple_cap_pkg.sv - shared types and constants for ripple_count_capture
// Contents: snapshot FSM state enum, default parameter values, and the
// active-low seven-segment hex table (segments a..g = bit0..bit6) used when
// SEG7_ACCEPT_EN is defined.
package ripple_cap_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

  localparam int DEF_CNT_W     = 4;
  localparam int DEF_EXT_W     = 8;
  localparam int DEF_STABLE_N  = 2;
  localparam int DEF_MAX_DELTA = 3;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/ripple_count_capture_sync_filter.sv
// rtl/ripple_count_capture_sync_filter.sv - 2-flop synchroniser plus stability filter
// Ports:
//   clk, clr (async active-low), q_in (raw count, asynchronous to clk)
//   accepted_o  : currently accepted count
//   candidate_o : value being accepted when accept_o is high
//   accept_o    : one-cycle strobe; the top extends the count on this edge
module sync_filter
  import ripple_cap_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int STABLE_N = DEF_STABLE_N
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [CNT_W-1:0] q_in,
  output logic [CNT_W-1:0] accepted_o,
  output logic [CNT_W-1:0] candidate_o,
  output logic             accept_o
);

  logic [CNT_W-1:0] s1_q, s2_q, cand_q, acc_q;
  logic [CNT_W-1:0] cand_d, acc_d;
  logic [2:0]       stab_q, stab_d;
  logic             accept;

  // Acceptance also needs s2 to still agree with the candidate, so a value must
  // be seen on STABLE_N+1 consecutive s2 samples before it is taken.
  always_comb begin
    accept = (stab_q == 3'(STABLE_N)) && (s2_q == cand_q) && (cand_q != acc_q);
    cand_d = cand_q;
    stab_d = stab_q;
    acc_d  = acc_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      stab_d = 3'd1;
    end else if (stab_q < 3'(STABLE_N)) begin
      stab_d = stab_q + 3'd1;
    end
    if (accept) acc_d = cand_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      stab_q <= '0;
      acc_q  <= '0;
    end else begin
      s1_q   <= q_in;
      s2_q   <= s1_q;
      cand_q <= cand_d;
      stab_q <= stab_d;
      acc_q  <= acc_d;
    end
  end

  assign accepted_o  = acc_q;
  assign candidate_o = cand_q;
  assign accept_o    = accept;

endmodule

// File: rtl/ripple_count_capture.sv
// rtl/ripple_count_capture.sv - ripple count capture, extension and snapshot handshake
// Ports:
//   clk, clr (async active-low), q_in (raw ripple count)
//   snap, out_ready            : snapshot request / downstream accept
//   out_valid, out_data        : held snapshot of the extended count
//   count_ext                  : live extended count
//   wrap_pulse, skip_err, overrun : raw-wrap pulse and sticky error flags
//   seg_n (only with SEG7_ACCEPT_EN) : active-low hex display of accepted count
module ripple_count_capture
  import ripple_cap_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int EXT_W     = DEF_EXT_W,
  parameter int STABLE_N  = DEF_STABLE_N,
  parameter int MAX_DELTA = DEF_MAX_DELTA
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [CNT_W-1:0] q_in,
  input  logic             snap,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [EXT_W-1:0] out_data,
  output logic [EXT_W-1:0] count_ext,
  output logic             wrap_pulse,
  output logic             skip_err,
  output logic             overrun
`ifdef SEG7_ACCEPT_EN
  ,
  output logic [6:0]       seg_n
`endif
);

  logic [CNT_W-1:0] accepted, candidate, delta;
  logic             accept;

  sync_filter #(
    .CNT_W   (CNT_W),
    .STABLE_N(STABLE_N)
  ) u_sync_filter (
    .clk        (clk),
    .clr        (clr),
    .q_in       (q_in),
    .accepted_o (accepted),
    .candidate_o(candidate),
    .accept_o   (accept)
  );

  logic [EXT_W-1:0] count_ext_q, count_ext_d;
  logic             wrap_q, wrap_d, skip_q, skip_d;

  // Modular difference covers both normal forward steps and raw wrap-around.
  always_comb begin
    delta       = candidate - accepted;
    count_ext_d = count_ext_q;
    wrap_d      = 1'b0;
    skip_d      = skip_q;
    if (accept) begin
      count_ext_d = count_ext_q + EXT_W'(delta);
      wrap_d      = (candidate < accepted);
      if (EXT_W'(delta) > EXT_W'(MAX_DELTA)) skip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_ext_q <= '0;
      wrap_q      <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      count_ext_q <= count_ext_d;
      wrap_q      <= wrap_d;
      skip_q      <= skip_d;
    end
  end

  snap_state_e      state_q;
  logic             out_valid_q, overrun_q;
  logic [EXT_W-1:0] out_data_q;

  // Snapshot takes count_ext_q, i.e. the pre-update value when an acceptance
  // lands on the same edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snap) begin
            out_data_q  <= count_ext_q;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (snap) overrun_q <= 1'b1;
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count_ext  = count_ext_q;
  assign wrap_pulse = wrap_q;
  assign skip_err   = skip_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign overrun    = overrun_q;

`ifdef SEG7_ACCEPT_EN
  logic [6:0] seg_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) seg_q <= 7'b1000000;
    else      seg_q <= SEG7_HEX[4'(accepted)];
  end

  assign seg_n = seg_q;
`endif

endmodule
